fire_alarm_ctrl: RTL
====================

# fire_alarm_ctrl

Sequencing controller for the fire-sensor display path. It synchronizes and debounces the raw flame-sensor input, then runs the SAFE/FIRE alarm state machine with post-clear hold and operator mute. It drives the message select, blink blanking and 4-digit anode scan consumed by the SAFE/FIRE seven-segment pattern generators and the top-level segment mux.

## Interface
- DEBOUNCE_CYC, 100000: consecutive synchronized-high cycles required to declare fire (1 ms @ 100 MHz); ≥2
- HOLD_CYC, 500000000: consecutive synchronized-low cycles before returning to SAFE (5 s); ≥2
- SCAN_CYC, 100000: cycles per anode digit slot; ≥2
- BLINK_CYC, 25000000: cycles per blink half-period; ≥2
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- sensor_in  in  1  raw flame sensor, asynchronous, 1 = flame
- ack  in  1  operator acknowledge button, asynchronous, level
- msg_sel  out  1  0 = show SAFE pattern, 1 = show FIRE pattern
- digit_idx  out  2  digit currently scanned, 0..3
- an  out  4  anode enables, active-low, one-cold
- blank  out  1  1 = force segments off (blink off-phase)
- buzzer  out  1  alarm sounder enable
- alarm_active  out  1  1 in FIRE or COOLDOWN
- fire_count  out  8  number of fire events since reset, saturating

## Operation
- sensor_in and ack each pass through a 2-FF synchronizer (sens_s, ack_s). ack rising edge is detected on ack_s.
- States: SAFE, DETECT, FIRE, COOLDOWN. There is a single cycle counter cnt, cleared on every state change.
- SAFE: sens_s=1 → DETECT.
- DETECT: sens_s=0 → SAFE. cnt==DEBOUNCE_CYC-1 with sens_s=1 → FIRE, and fire_count increments (holds at 255).
- FIRE: sens_s=0 → COOLDOWN. An ack rising edge sets mute.
- COOLDOWN: sens_s=1 → FIRE (no fire_count increment). cnt==HOLD_CYC-1 with sens_s=0 → SAFE.
- mute is cleared on entry to SAFE and ignored outside FIRE/COOLDOWN. An ack edge in SAFE/DETECT has no effect.
- Output decode:
  - msg_sel = alarm_active = (FIRE|COOLDOWN)
  - buzzer = FIRE & ~mute
  - blink runs only in FIRE & ~mute; otherwise blank=0 and the blink counter is held at 0 with phase = on
- Scan runs continuously in all states: digit_idx advances every SCAN_CYC cycles, wrapping 3→0. an = ~(4'b0001 << digit_idx).
- All outputs are registered.

## Timing
- Reset values: state SAFE, cnt 0, mute 0, msg_sel 0, alarm_active 0, buzzer 0, blank 0, digit_idx 0, an 4'b1110, fire_count 0, synchronizers 0.
- Assertion of rst at any time forces the reset values asynchronously, including mid-DETECT or mid-COOLDOWN. Release restarts in SAFE.
- sensor_in rising → DETECT: sensor_in sampled 1 at edge 0 gives sens_s=1 after edge 1, so state=DETECT after edge 2.
- DETECT → FIRE: state=FIRE, and msg_sel/buzzer=1 together, after edge 2+DEBOUNCE_CYC if sensor_in stays high.
- A single low synchronized cycle in DETECT returns to SAFE and restarts the debounce.
- FIRE → COOLDOWN: 2 cycles after sensor_in falls. COOLDOWN → SAFE: HOLD_CYC cycles later.
- Simultaneous sens_s change and cnt terminal in the same cycle: the sens_s condition wins.
- Each digit is held exactly SCAN_CYC cycles. blank toggles every BLINK_CYC cycles; the first toggle comes BLINK_CYC cycles after FIRE entry or mute clear.
- Outputs change only on clk edges or asynchronous rst. There are no combinational paths from inputs.

## Structure
- Package fire_alarm_pkg holds:
  - state enum {SAFE, DETECT, FIRE, COOLDOWN} (2 bits)
  - AN_ALL_OFF = 4'b1111
  - FIRE_COUNT_MAX = 8'd255
- Sub-module disp_scan_timer (params SCAN_CYC, BLINK_CYC; inputs blink_en; outputs digit_idx, an, blank) contains the scan counter and the blink counter.
- The FSM, synchronizers and counters stay in fire_alarm_ctrl.

## Test plan
Params for all scenarios: DEBOUNCE_CYC=4, HOLD_CYC=8, SCAN_CYC=3, BLINK_CYC=5.
- Reset: assert rst mid-run → outputs at reset values immediately, an=1110, fire_count=0.
- Debounce reject: sensor_in high 3 cycles then low → never leaves SAFE/DETECT, msg_sel=0, fire_count=0. High for 10 cycles → msg_sel=1 after edge 6, buzzer=1, fire_count=1.
- Hold/re-trigger: in FIRE, sensor low 5 cycles then high → COOLDOWN then FIRE again, fire_count stays 1. Sensor low ≥10 cycles → SAFE exactly 8 cycles after COOLDOWN entry, msg_sel=0.
- Mute: ack pulse in FIRE → buzzer=0 and blank=0 within 3 cycles, msg_sel stays 1. After return to SAFE and a new fire → buzzer=1 and fire_count=2.
- Scan: an sequence 1110,1101,1011,0111,1110, each held 3 cycles, in every state. In unmuted FIRE, blank toggles every 5 cycles.
- Saturation: 300 debounced fire events → fire_count=255 and holds.

Source files
------------

// File: rtl/fire_alarm_pkg.sv
// fire_alarm_pkg
// Shared types and constants for the fire-alarm display sequencer.
//   state_t        : alarm state machine encoding (SAFE, DETECT, FIRE, COOLDOWN)
//   AN_ALL_OFF     : anode bus value with every digit disabled (active-low)
//   FIRE_COUNT_MAX : saturation value of the fire event counter
//   an_decode()    : one-cold anode pattern for a digit index
package fire_alarm_pkg;

  typedef enum logic [1:0] {
    SAFE     = 2'd0,
    DETECT   = 2'd1,
    FIRE     = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  localparam logic [3:0] AN_ALL_OFF     = 4'b1111;
  localparam logic [7:0] FIRE_COUNT_MAX = 8'd255;

  // Clear the single anode bit belonging to idx; all others stay off.
  function automatic logic [3:0] an_decode(input logic [1:0] idx);
    return AN_ALL_OFF & ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/fire_alarm_ctrl_disp_scan_timer.sv
// disp_scan_timer
// Free-running 4-digit anode scan plus the alarm blink generator.
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   blink_en  in   1 = blink should be running from this edge on
//   digit_idx out  digit currently scanned, advances every SCAN_CYC cycles
//   an        out  active-low one-cold anode enables matching digit_idx
//   blank     out  1 = blink off-phase, segments forced dark
module disp_scan_timer
  import fire_alarm_pkg::*;
#(
  parameter int SCAN_CYC  = 100000,
  parameter int BLINK_CYC = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       blink_en,
  output logic [1:0] digit_idx,
  output logic [3:0] an,
  output logic       blank
);

  localparam int SCAN_W  = $clog2(SCAN_CYC);
  localparam int BLINK_W = $clog2(BLINK_CYC);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_CYC - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYC - 1);

  logic [SCAN_W-1:0]  scan_cnt_reg;
  logic [BLINK_W-1:0] blink_cnt_reg;
  logic               blink_on_reg;

  // Scan never stops, whatever the alarm state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_reg <= '0;
      digit_idx    <= 2'd0;
      an           <= an_decode(2'd0);
    end else if (scan_cnt_reg == SCAN_LAST) begin
      scan_cnt_reg <= '0;
      digit_idx    <= digit_idx + 2'd1;
      an           <= an_decode(digit_idx + 2'd1);
    end else begin
      scan_cnt_reg <= scan_cnt_reg + SCAN_W'(1);
    end
  end

  // blink_en is the enable the alarm logic is about to register, so blank
  // drops on the same edge the buzzer does. blink_on_reg remembers that
  // the enable was already high; on the first enabled edge the counter is
  // restarted from zero so the first toggle lands BLINK_CYC cycles after
  // the enable took effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_reg <= '0;
      blink_on_reg  <= 1'b0;
      blank         <= 1'b0;
    end else begin
      blink_on_reg <= blink_en;
      if (!blink_en) begin
        blink_cnt_reg <= '0;
        blank         <= 1'b0;
      end else if (!blink_on_reg) begin
        blink_cnt_reg <= '0;
      end else if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_reg <= '0;
        blank         <= ~blank;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
      end
    end
  end

endmodule

// File: rtl/fire_alarm_ctrl.sv
// fire_alarm_ctrl
// Debounces the flame sensor and sequences the SAFE/FIRE alarm display.
//   clk          in   system clock, all logic on rising edge
//   rst          in   asynchronous active-high reset
//   sensor_in    in   raw flame sensor (async), 1 = flame
//   ack          in   operator acknowledge button (async, level)
//   msg_sel      out  0 = SAFE pattern, 1 = FIRE pattern
//   digit_idx    out  digit being scanned, 0..3
//   an           out  active-low one-cold anode enables
//   blank        out  1 = segments forced off (blink off-phase)
//   buzzer       out  alarm sounder enable
//   alarm_active out  1 while in FIRE or COOLDOWN
//   fire_count   out  saturating count of fire events since reset
module fire_alarm_ctrl
  import fire_alarm_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 100000,
  parameter int HOLD_CYC     = 500000000,
  parameter int SCAN_CYC     = 100000,
  parameter int BLINK_CYC    = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_in,
  input  logic       ack,
  output logic       msg_sel,
  output logic [1:0] digit_idx,
  output logic [3:0] an,
  output logic       blank,
  output logic       buzzer,
  output logic       alarm_active,
  output logic [7:0] fire_count
);

  localparam int CNT_MAX = (HOLD_CYC > DEBOUNCE_CYC) ? HOLD_CYC : DEBOUNCE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

  logic [1:0]       sens_sync_reg;
  logic [1:0]       ack_sync_reg;
  logic             ack_d_reg;
  logic             sens_s;
  logic             ack_s;
  logic             ack_rise;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             mute_reg, mute_next;
  logic             fire_inc;
  logic             alarm_next;
  logic             buzzer_next;

  assign sens_s   = sens_sync_reg[1];
  assign ack_s    = ack_sync_reg[1];
  assign ack_rise = ack_s & ~ack_d_reg;

  always_comb begin
    state_next = state_reg;
    mute_next  = mute_reg;
    fire_inc   = 1'b0;
    case (state_reg)
      SAFE: begin
        if (sens_s) state_next = DETECT;
      end
      DETECT: begin
        // A low sample always wins over the terminal count.
        if (!sens_s) begin
          state_next = SAFE;
        end else if (cnt_reg == DEB_LAST) begin
          state_next = FIRE;
          fire_inc   = 1'b1;
        end
      end
      FIRE: begin
        if (!sens_s) state_next = COOLDOWN;
        if (ack_rise) mute_next = 1'b1;
      end
      COOLDOWN: begin
        // Re-ignition is the same incident, so no new count.
        if (sens_s) begin
          state_next = FIRE;
        end else if (cnt_reg == HOLD_LAST) begin
          state_next = SAFE;
        end
      end
      default: state_next = SAFE;
    endcase

    if (state_next == SAFE) mute_next = 1'b0;

    // Only DETECT and COOLDOWN time anything; elsewhere cnt rests at 0.
    if (state_next != state_reg) begin
      cnt_next = '0;
    end else if (state_reg == DETECT || state_reg == COOLDOWN) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end else begin
      cnt_next = '0;
    end
  end

  // Outputs are registered from next-state values so they switch on the
  // same edge as the state itself.
  assign alarm_next  = (state_next == FIRE) || (state_next == COOLDOWN);
  assign buzzer_next = (state_next == FIRE) && !mute_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sens_sync_reg <= 2'b00;
      ack_sync_reg  <= 2'b00;
      ack_d_reg     <= 1'b0;
      state_reg     <= SAFE;
      cnt_reg       <= '0;
      mute_reg      <= 1'b0;
      msg_sel       <= 1'b0;
      alarm_active  <= 1'b0;
      buzzer        <= 1'b0;
      fire_count    <= 8'd0;
    end else begin
      sens_sync_reg <= {sens_sync_reg[0], sensor_in};
      ack_sync_reg  <= {ack_sync_reg[0], ack};
      ack_d_reg     <= ack_s;
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      mute_reg      <= mute_next;
      msg_sel       <= alarm_next;
      alarm_active  <= alarm_next;
      buzzer        <= buzzer_next;
      if (fire_inc && fire_count != FIRE_COUNT_MAX) begin
        fire_count <= fire_count + 8'd1;
      end
    end
  end

  disp_scan_timer #(
    .SCAN_CYC (SCAN_CYC),
    .BLINK_CYC(BLINK_CYC)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .blink_en (buzzer_next),
    .digit_idx(digit_idx),
    .an       (an),
    .blank    (blank)
  );

endmodule
